// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite slave exposing NUM_REGS x 32-bit registers, also driven flat on regs_q.
// Define AXIL_REGFILE_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi4_lite_regfile_slave #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS           = 4
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] regs_q
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned IW = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [1:0]  RESP_OKAY = 2'b00;
`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0]  RESP_OOR  = 2'b10;
`else
  localparam logic [1:0]  RESP_OOR  = 2'b00;
`endif

  logic          aw_full_q, aw_full_d;
  logic [IW-1:0] aw_idx_q, aw_idx_d;
  logic          w_full_q, w_full_d;
  logic [DW-1:0] w_data_q, w_data_d;
  logic [SW-1:0] w_strb_q, w_strb_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          rvalid_q, rvalid_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW*NUM_REGS-1:0] regs_d;

  logic aw_ready_c, w_ready_c, ar_ready_c;
  logic [IW-1:0] ar_idx_c;

  // Readies depend on registered state only.
  assign aw_ready_c = !aw_full_q && !bvalid_q;
  assign w_ready_c  = !w_full_q && !bvalid_q;
  assign ar_ready_c = !rvalid_q;
  assign ar_idx_c   = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  assign S_AXI_AWREADY = aw_ready_c;
  assign S_AXI_WREADY  = w_ready_c;
  assign S_AXI_ARREADY = ar_ready_c;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

  logic unused_sigs;
  assign unused_sigs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    regs_d    = regs_q;

    if (S_AXI_AWVALID && aw_ready_c) begin
      aw_full_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    end
    if (S_AXI_WVALID && w_ready_c) begin
      w_full_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end

    // Commit once both halves are buffered; out-of-range writes are dropped.
    if (aw_full_q && w_full_q && !bvalid_q) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_OOR;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (aw_idx_q == IW'(i)) begin
          bresp_d = RESP_OKAY;
          for (int unsigned b = 0; b < SW; b++) begin
            if (w_strb_q[b]) regs_d[DW*i+8*b +: 8] = w_data_q[8*b +: 8];
          end
        end
      end
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    // Read samples regs_q, so a same-edge commit is not yet visible.
    if (S_AXI_ARVALID && ar_ready_c) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_OOR;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (ar_idx_c == IW'(i)) begin
          rdata_d = regs_q[DW*i +: DW];
          rresp_d = RESP_OKAY;
        end
      end
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      regs_q    <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      regs_q    <= regs_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Scoreboard bench for axi4_lite_regfile_slave: reference register array plus B/R expectation queues.
module tb_axi4_lite_regfile_slave;

  localparam int NREG = 4;
`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [4:0]   awaddr = '0, araddr = '0;
  logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [127:0] regs;

  axi4_lite_regfile_slave dut (
    .ACLK(clk), .ARESETN(rstn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .regs_q(regs)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [NREG];
  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [127:0] flat();
    logic [127:0] f;
    for (int i = 0; i < NREG; i++) f[32*i +: 32] = mdl[i];
    return f;
  endfunction

  // Reference: bytes with strobe set take new data; out-of-range targets are untouched.
  function automatic void exp_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    logic [31:0] mask;
    idx = int'(a) / 4;
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = s[b] ? 8'hFF : 8'h00;
    if (idx < NREG) begin
      mdl[idx] = (mdl[idx] & ~mask) | (d & mask);
      exp_b.push_back(2'b00);
    end else begin
      exp_b.push_back(ERR);
    end
  endfunction

  function automatic void exp_read(input logic [4:0] a);
    int idx;
    idx = int'(a) / 4;
    if (idx < NREG) exp_r.push_back({2'b00, mdl[idx]});
    else            exp_r.push_back({ERR, 32'h0});
  endfunction

  // Monitor: responses are compared at the cycle their handshake completes.
  always @(negedge clk) begin
    if (bvalid && bready) begin
      if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
      else chk("bresp", bresp, exp_b.pop_front());
    end
    if (rvalid && rready) begin
      if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
      else chk("rresp_rdata", {rresp, rdata}, exp_r.pop_front());
    end
  end

  task automatic drive_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int d_aw, input int d_w, input int hold);
    int aw_c, w_c, bc, last;
    logic [1:0] r0;
    aw_c = -1; w_c = -1; bc = -1;
    fork
      begin
        repeat (d_aw) begin @(posedge clk); #1; end
        awaddr = a; awvalid = 1'b1;
        for (int k = 0; k < 50; k++) begin
          if (awready) begin @(posedge clk); #1; aw_c = cyc; break; end
          @(posedge clk); #1;
        end
        awvalid = 1'b0;
      end
      begin
        repeat (d_w) begin @(posedge clk); #1; end
        wdata = d; wstrb = s; wvalid = 1'b1;
        for (int k = 0; k < 50; k++) begin
          if (wready) begin @(posedge clk); #1; w_c = cyc; break; end
          @(posedge clk); #1;
        end
        wvalid = 1'b0;
      end
    join
    if (aw_c < 0 || w_c < 0) chk("aw_w_handshake_timeout", 1, 0);
    last = (aw_c > w_c) ? aw_c : w_c;
    for (int k = 0; k < 50; k++) begin
      if (bvalid) begin bc = cyc; break; end
      @(posedge clk); #1;
    end
    if (bc < 0) begin
      chk("bvalid_timeout", 1, 0);
      return;
    end
    chk("b_latency", 128'(bc - last), 128'(1));
    r0 = bresp;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("b_hold_valid", bvalid, 1);
      chk("b_hold_resp", bresp, r0);
      chk("b_hold_awready", awready, 0);
      chk("b_hold_wready", wready, 0);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("b_cleared", bvalid, 0);
    chk("regs_after_write", regs, flat());
  endtask

  task automatic drive_read(input logic [4:0] a, input int dly, input int hold);
    bit ok;
    logic [33:0] v0;
    ok = 1'b0;
    repeat (dly) begin @(posedge clk); #1; end
    araddr = a; arvalid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (arready) begin @(posedge clk); #1; ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    if (!ok) begin
      chk("ar_handshake_timeout", 1, 0);
      return;
    end
    chk("r_valid_after_ar", rvalid, 1);
    v0 = {rresp, rdata};
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("r_hold_valid", rvalid, 1);
      chk("r_hold_data", {rresp, rdata}, v0);
      chk("r_hold_arready", arready, 0);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("r_cleared", rvalid, 0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int d_aw, input int d_w, input int hold);
    exp_write(a, d, s);
    drive_write(a, d, s, d_aw, d_w, hold);
  endtask

  task automatic rd(input logic [4:0] a, input int dly, input int hold);
    exp_read(a);
    drive_read(a, dly, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [4:0]  a;
    logic [31:0] d;
    for (int i = 0; i < NREG; i++) mdl[i] = '0;

    // Reset
    repeat (10) @(posedge clk);
    #1;
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_regs", regs, 128'h0);
    chk("rst_resp_data", {bresp, rresp, rdata}, 36'h0);
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_arready", arready, 1);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Fill and read back every register
    for (int i = 0; i < NREG; i++) wr(5'(4*i), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < NREG; i++) rd(5'(4*i), 0, 0);
    chk("regs_1234", regs, 128'h00000004_00000003_00000002_00000001);

    // W three cycles ahead of AW
    wr(5'h04, 32'hDEADBEEF, 4'hF, 3, 0, 0);
    chk("reg1_deadbeef", regs[63:32], 32'hDEADBEEF);

    // Partial strobes
    wr(5'h00, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    wr(5'h00, 32'h12345678, 4'b0101, 0, 1, 0);
    chk("reg0_strobed", regs[31:0], 32'hFF34FF78);

    // Out of range
    wr(5'h10, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    rd(5'h1C, 0, 0);
    wr(5'h08, 32'h0000000A, 4'h0, 1, 0, 0);

    // Back-pressure, then a read capturing on the commit edge of the same register
    wr(5'h08, 32'h0000000A, 4'hF, 0, 0, 5);
    rd(5'h08, 0, 5);
    exp_read(5'h08);
    exp_write(5'h08, 32'h0000000B, 4'hF);
    fork
      drive_write(5'h08, 32'h0000000B, 4'hF, 0, 0, 0);
      drive_read(5'h08, 1, 0);
    join
    chk("reg2_new", regs[95:64], 32'h0000000B);

    // Random traffic
    for (int t = 0; t < 60; t++) begin
      a = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        wr(a, d, 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 2)));
      end else begin
        rd(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end
    end

    // Reset between buffer fill and commit drops the write
    awaddr = 5'h0C; awvalid = 1'b1; wdata = 32'h55AA55AA; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < NREG; i++) mdl[i] = '0;
    for (int k = 0; k < 3; k++) begin
      chk("abort_no_bvalid", bvalid, 0);
      @(posedge clk); #1;
    end
    chk("abort_regs", regs, 128'h0);
    rd(5'h0C, 0, 0);

    @(posedge clk); #1;
    chk("exp_b_drained", 128'(exp_b.size()), 128'(0));
    chk("exp_r_drained", 128'(exp_r.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
